// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rng_pkg
// Brief   : Shared types and default sizes for the RNG word collector.
// Revision: 1.0
// ============================================================================
package rng_pkg;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } pair_state_t;

    localparam int RNG_WORD_W    = 32;
    localparam int RNG_REP_LIMIT = 8;
    localparam int RNG_DROP_W    = 8;

endpackage
`default_nettype wire

// File: rtl/rng_word_collector_vn_debias.sv
`default_nettype none
// ============================================================================
// Module  : vn_debias
// Brief   : von Neumann pair corrector; pass-through when disabled.
// Revision: 1.0
// ============================================================================
module vn_debias
    import rng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_valid_i,
    input  logic bit_in_i,
    input  logic en_i,
    input  logic flush_i,
    output logic out_valid_o,
    output logic out_bit_o
);

    pair_state_t state_q;
    logic        first_q;

    // The enable only matters in IDLE; a started pair always completes.
    always_comb begin
        out_valid_o = 1'b0;
        out_bit_o   = bit_in_i;
        if (bit_valid_i && !flush_i) begin
            if (state_q == IDLE) begin
                out_valid_o = !en_i;
            end else begin
                out_valid_o = (first_q != bit_in_i);
                out_bit_o   = first_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else if (bit_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        first_q <= bit_in_i;
                        state_q <= HAVE_FIRST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rng_word_collector.sv
`default_nettype none
// ============================================================================
// Module  : rng_word_collector
// Brief   : Health-tests, debiases and packs RNG bits into valid/ready words.
// Revision: 1.0
// ============================================================================
module rng_word_collector
    import rng_pkg::*;
#(
    parameter int WIDTH     = RNG_WORD_W,
    parameter int REP_LIMIT = RNG_REP_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_valid_i,
    input  logic                  bit_in_i,
    input  logic                  debias_en_i,
    input  logic                  fail_clr_i,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic [WIDTH-1:0]      word_data_o,
    output logic                  health_fail_o,
    output logic [RNG_DROP_W-1:0] drop_cnt_o
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       REP_LIM  = 8'(REP_LIMIT);

    logic [7:0]            rep_cnt_q, rep_cnt_d;
    logic                  prev_q, have_prev_q, health_fail_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]      shift_q, shift_d, load_word;
    logic [WIDTH-1:0]      word_q;
    logic                  word_valid_q;
    logic [RNG_DROP_W-1:0] drop_cnt_q;

    logic take, trip, emit_valid, emit_bit, out_free, load_out, drop_inc;

    // A fail_clr cycle takes no bit, so the clear always wins over a trip.
    assign take      = bit_valid_i && !health_fail_q && !fail_clr_i;
    assign rep_cnt_d = (have_prev_q && (bit_in_i == prev_q)) ? rep_cnt_q + 8'd1 : 8'd1;
    assign trip      = take && (rep_cnt_d == REP_LIM);
    assign out_free  = !word_valid_q || word_ready_i;

    vn_debias u_debias (
        .clk         (clk),
        .rst         (rst),
        .bit_valid_i (take),
        .bit_in_i    (bit_in_i),
        .en_i        (debias_en_i),
        .flush_i     (trip),
        .out_valid_o (emit_valid),
        .out_bit_o   (emit_bit)
    );

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load_out  = 1'b0;
        load_word = shift_q;
        drop_inc  = 1'b0;
        if (trip) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (bit_cnt_q == CNT_FULL) begin
            // Stalled full word: release it when the output frees up.
            if (out_free) begin
                load_out = 1'b1;
                if (emit_valid) begin
                    shift_d   = {shift_q[WIDTH-2:0], emit_bit};
                    bit_cnt_d = CNT_W'(1);
                end else begin
                    bit_cnt_d = '0;
                end
            end else if (emit_valid) begin
                drop_inc = 1'b1;
            end
        end else if (emit_valid) begin
            shift_d = {shift_q[WIDTH-2:0], emit_bit};
            if (bit_cnt_q == CNT_LAST && out_free) begin
                load_out  = 1'b1;
                load_word = shift_d;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q     <= '0;
            prev_q        <= 1'b0;
            have_prev_q   <= 1'b0;
            health_fail_q <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            if (fail_clr_i) begin
                health_fail_q <= 1'b0;
                rep_cnt_q     <= '0;
                have_prev_q   <= 1'b0;
            end else if (take) begin
                rep_cnt_q   <= rep_cnt_d;
                prev_q      <= bit_in_i;
                have_prev_q <= 1'b1;
                if (trip) begin
                    health_fail_q <= 1'b1;
                end
            end
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            if (load_out) begin
                word_valid_q <= 1'b1;
                word_q       <= load_word;
            end else if (word_ready_i) begin
                word_valid_q <= 1'b0;
            end
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign word_valid_o  = word_valid_q;
    assign word_data_o   = word_q;
    assign health_fail_o = health_fail_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_word_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_rng_word_collector
// Brief   : Directed vector bench for rng_word_collector (WIDTH=8, REP_LIMIT=8).
// Revision: 1.0
// ============================================================================
module tb_rng_word_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_valid_i = 1'b0;
    logic       bit_in_i = 1'b0;
    logic       debias_en_i = 1'b0;
    logic       fail_clr_i = 1'b0;
    logic       word_ready_i = 1'b1;
    logic       word_valid_o;
    logic [7:0] word_data_o;
    logic       health_fail_o;
    logic [7:0] drop_cnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] raw;
        int          n;
        logic        deb;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[4];

    rng_word_collector #(.WIDTH(8), .REP_LIMIT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_valid_i   (bit_valid_i),
        .bit_in_i      (bit_in_i),
        .debias_en_i   (debias_en_i),
        .fail_clr_i    (fail_clr_i),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .word_data_o   (word_data_o),
        .health_fail_o (health_fail_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe one bit; returns at the negedge right after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid_i = 1'b1;
        bit_in_i    = b;
        @(negedge clk);
        bit_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        logic       early;

        vecs[0] = '{raw: 32'h000000B2, n: 8,  deb: 1'b0, exp: 8'hB2};
        vecs[1] = '{raw: 32'h000639A5, n: 20, deb: 1'b1, exp: 8'h6C};
        vecs[2] = '{raw: 32'h000000A5, n: 8,  deb: 1'b0, exp: 8'hA5};
        vecs[3] = '{raw: 32'h0000003C, n: 8,  deb: 1'b0, exp: 8'h3C};

        idle(2);
        check("reset_valid", {31'd0, word_valid_o}, 32'd0);
        check("reset_data", {24'd0, word_data_o}, 32'd0);
        check("reset_health", {31'd0, health_fail_o}, 32'd0);
        check("reset_drop", {24'd0, drop_cnt_o}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Table-driven words, strobes 4 cycles apart, consumer always ready.
        word_ready_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            debias_en_i = vecs[v].deb;
            early = 1'b0;
            for (int i = vecs[v].n - 1; i >= 0; i--) begin
                send_bit(vecs[v].raw[i]);
                if (i != 0) begin
                    if (word_valid_o) early = 1'b1;
                    idle(2);
                end
            end
            check($sformatf("vec%0d_early", v), {31'd0, early}, 32'd0);
            check($sformatf("vec%0d_valid", v), {31'd0, word_valid_o}, 32'd1);
            check($sformatf("vec%0d_data", v), {24'd0, word_data_o}, {24'd0, vecs[v].exp});
            idle(1);
            check($sformatf("vec%0d_valid_drop", v), {31'd0, word_valid_o}, 32'd0);
            idle(2);
        end
        debias_en_i = 1'b0;

        // Back-pressure: two words, second stalls, five bits dropped.
        word_ready_i = 1'b0;
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        check("bp_w1_valid", {31'd0, word_valid_o}, 32'd1);
        check("bp_w1_data", {24'd0, word_data_o}, 32'h5A);
        w = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        check("bp_hold_data", {24'd0, word_data_o}, 32'h5A);
        check("bp_drop5", {24'd0, drop_cnt_o}, 32'd5);
        idle(3);
        check("bp_hold_late", {24'd0, word_data_o}, 32'h5A);
        word_ready_i = 1'b1;
        @(negedge clk);
        check("bp_w2_valid", {31'd0, word_valid_o}, 32'd1);
        check("bp_w2_data", {24'd0, word_data_o}, 32'hC3);
        @(negedge clk);
        check("bp_w2_gone", {31'd0, word_valid_o}, 32'd0);

        // Health trip: 0,1,0 then eight 1s; word 0x5F completes on the way.
        do_reset();
        word_ready_i = 1'b1;
        w = 8'h5F;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            idle(2);
        end
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
            if (i == 0) check("trip_word_data", {24'd0, word_data_o}, 32'h5F);
            if (i == 1) check("trip_before", {31'd0, health_fail_o}, 32'd0);
            if (i == 2) check("trip_set", {31'd0, health_fail_o}, 32'd1);
            idle(2);
        end
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0]);
            if (word_valid_o) early = 1'b1;
        end
        check("trip_ignored", {31'd0, early}, 32'd0);
        check("trip_sticky", {31'd0, health_fail_o}, 32'd1);
        @(negedge clk);
        fail_clr_i = 1'b1;
        @(negedge clk);
        fail_clr_i = 1'b0;
        check("trip_cleared", {31'd0, health_fail_o}, 32'd0);
        w = 8'h96;
        early = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0 && word_valid_o) early = 1'b1;
        end
        check("clr_early", {31'd0, early}, 32'd0);
        check("clr_word_valid", {31'd0, word_valid_o}, 32'd1);
        check("clr_word_data", {24'd0, word_data_o}, 32'h96);

        // Saturation: two alternating words fill the path, then 300 drops.
        do_reset();
        word_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        check("sat_word", {24'd0, word_data_o}, 32'hAA);
        for (int k = 1; k <= 300; k++) begin
            send_bit(k[0]);
            if (k == 254) check("sat_254", {24'd0, drop_cnt_o}, 32'd254);
            if (k == 255) check("sat_255", {24'd0, drop_cnt_o}, 32'd255);
        end
        check("sat_300", {24'd0, drop_cnt_o}, 32'd255);

        // Reset mid-operation with a held word and a partial word.
        do_reset();
        word_ready_i = 1'b0;
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        check("mid_valid_before", {31'd0, word_valid_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, word_valid_o}, 32'd0);
        check("mid_rst_data", {24'd0, word_data_o}, 32'd0);
        check("mid_rst_health", {31'd0, health_fail_o}, 32'd0);
        check("mid_rst_drop", {24'd0, drop_cnt_o}, 32'd0);
        rst = 1'b0;
        word_ready_i = 1'b1;
        w = 8'h33;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) idle(2);
        end
        check("mid_fresh_valid", {31'd0, word_valid_o}, 32'd1);
        check("mid_fresh_data", {24'd0, word_data_o}, 32'h33);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rng_word_collector.md
# rng_word_collector

Consumer end of the hysteresis ring-oscillator RNG bit stream. Samples the generator's `done`/`rnd_bit` strobe pair, optionally removes bias with a von Neumann corrector, runs a repetition-count health test on the raw bits, and packs accepted bits into `WIDTH`-bit words. Words leave through a valid/ready output register toward the bus or host FIFO.

## Interface
- `WIDTH`, 32: output word width; legal range is 8–64.
- `REP_LIMIT`, 8: the number of consecutive identical raw bits that trips the health test; legal range is 2–255.
- `clk`  in  1  single clock; the RNG strobes are already synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `bit_valid`  in  1  raw-bit strobe, driven by the generator's `done`.
- `bit_in`  in  1  raw bit, driven by `rnd_bit`; sampled only when `bit_valid`=1.
- `debias_en`  in  1  1 = von Neumann correction on; sample it only when the pair FSM is in IDLE.
- `fail_clr`  in  1  1-cycle pulse that clears `health_fail` and the repetition counter.
- `word_valid`  out  1  output word available.
- `word_ready`  in  1  consumer accepts the word.
- `word_data`  out  WIDTH  packed word; the first accepted bit is the MSB.
- `health_fail`  out  1  sticky flag: the repetition-count test has tripped.
- `drop_cnt`  out  8  saturating count of bits dropped because of back-pressure.

## Operation
- A raw bit is taken when `bit_valid`=1 and `health_fail`=0. Ignore `bit_valid` while `health_fail`=1.
- **Health test** (raw bits, before debias):
  - `rep_cnt` (8 b) resets to 1 when a bit differs from the previous raw bit and increments when it matches.
  - When `rep_cnt` reaches `REP_LIMIT`, set `health_fail` in the same cycle.
  - Trip side effects: clear the assembly shift register and its bit count, and return the pair FSM to IDLE.
  - The output register is not affected by a trip.
  - `health_fail` clears only on `rst` or `fail_clr`. `fail_clr` also sets `rep_cnt`=0 and forgets the previous bit.
- **Pair FSM** (active when `debias_en`=1):
  - IDLE: a raw bit stores `first` and moves to HAVE_FIRST.
  - HAVE_FIRST: a raw bit returns to IDLE. Pair 01 emits 0, pair 10 emits 1, pairs 00 and 11 emit nothing.
  - When `debias_en`=0 the FSM stays in IDLE and every raw bit is emitted unchanged.
- **Assembly:** each emitted bit shifts in at the LSB and increments `bit_cnt`, a clog2(`WIDTH`+1)-bit counter.
- **Word complete** (`bit_cnt`=`WIDTH`):
  - If the output register is empty, or is being drained this cycle (`word_valid`&`word_ready`), the word transfers in the next cycle, `bit_cnt` returns to 0, and assembly continues without a gap.
  - Otherwise assembly stalls full. Every emitted bit that arrives during the stall is dropped and increments `drop_cnt`, which saturates at 255.
  - The health test and pair FSM keep running during the stall.
- **Output handshake:**
  - `word_valid` stays high and `word_data` stays stable until `word_valid`&`word_ready`.
  - `word_ready` may toggle freely while `word_valid`=0.
- **Simultaneous events:**
  - A health trip and word completion on the same bit: the trip wins and the word is discarded.
  - `fail_clr` together with a trip-causing bit: the clear wins and the bit is not counted.

## Timing
- Reset values:
  - Outputs: `word_valid`=0, `word_data`=0, `health_fail`=0, `drop_cnt`=0.
  - Internal state: pair FSM in IDLE, `bit_cnt`=0, `rep_cnt`=0.
- Latency: `word_valid` rises 1 cycle after the `clk` edge that accepts the bit completing the word.
- Maximum accepted rate is 1 raw bit per cycle. The generator delivers 1 bit per 4 cycles.
- `health_fail` rises 1 cycle after the edge that samples the `REP_LIMIT`-th identical bit.
- `rst` mid-word discards the partial word and any held output word.

## Structure
- Package `rng_pkg`:
  - `pair_state_t` enum {IDLE, HAVE_FIRST}.
  - Default constants `RNG_WORD_W`=32 and `RNG_REP_LIMIT`=8.
  - Width of `drop_cnt`: `RNG_DROP_W`=8.
- Sub-module `vn_debias`: owns the pair FSM. Inputs `bit_valid`, `bit_in`, `en`, `flush`; outputs `out_valid`, `out_bit`.
- The top level holds the health counter, shift register, output register and drop counter.

## Test plan
- **Bypass packing:** `debias_en`=0, `WIDTH`=8, bits 1,0,1,1,0,0,1,0 on strobes spaced 4 cycles apart, `word_ready`=1 → `word_data`=8'hB2, `word_valid` for exactly 1 cycle, starting 1 cycle after the 8th strobe.
- **Debias:** `debias_en`=1, raw pairs 01,10,00,11,10,01,10,10,01,01 → emitted bits 0,1,1,0,1,1,0,0 → `word_data`=8'h6C.
- **Back-pressure:** `word_ready`=0, 2 full words sent → the first word is held stable, the second completes and stalls, and 5 further bits give `drop_cnt`=5. Raising `word_ready` gives word 1, then 1 cycle later word 2, with no data change while waiting.
- **Health trip:** `REP_LIMIT`=8, 3 mixed bits then 8 consecutive 1s → `health_fail`=1 one cycle after the 8th 1. `bit_cnt` is cleared, later strobes are ignored, and `fail_clr` restores collection from an empty word.
- **Saturation:** 300 bits dropped while stalled → `drop_cnt` holds at 255.
- **Reset mid-operation:** `rst` asserted after 5 bits with `word_valid`=1 → all outputs return to their reset values in the next cycle, and the following word starts fresh at the MSB.
